// File: rtl/lane_delay_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_delay_fifo_pkg
// Purpose  : Clock constants and the deployed delay-line configurations.
// Revision : 1.0 - initial release
// ============================================================================
package lane_delay_fifo_pkg;

    localparam int CLK_PERIOD_NS      = 10;
    localparam int CLK_HALF_PERIOD_NS = CLK_PERIOD_NS / 2;

    localparam int SA_LANES           = 16;

    // Partial-sum path: short, wide lanes.
    localparam int PSUM_FIFO_DEPTH    = 16;
    localparam int PSUM_WIDTH         = 20;

    // Operand path: long, narrow lanes.
    localparam int OPND_FIFO_DEPTH    = 256;
    localparam int OPND_WIDTH         = 8;

endpackage : lane_delay_fifo_pkg
`default_nettype wire

// File: rtl/lane_delay_stage.sv
`default_nettype none
// ============================================================================
// Module   : lane_delay_stage
// Purpose  : One full lane-vector register with shift enable and async clear.
// Revision : 1.0 - initial release
// ============================================================================
module lane_delay_stage #(
    parameter int DATA_W = 320
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : lane_delay_stage
`default_nettype wire

// File: rtl/lane_delay_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lane_delay_fifo
// Purpose  : Fixed-latency multi-lane delay line built as a DEPTH-stage chain.
// Revision : 1.0 - initial release
// ============================================================================
module lane_delay_fifo
    import lane_delay_fifo_pkg::*;
#(
    parameter int DEPTH = PSUM_FIFO_DEPTH,
    parameter int LANES = SA_LANES,
    parameter int WIDTH = PSUM_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [LANES*WIDTH-1:0] din,
    output logic [LANES*WIDTH-1:0] dout
);

    localparam int c_VEC_W = LANES * WIDTH;

    logic [DEPTH-1:0][c_VEC_W-1:0] w_stage_q;

    // Every stage shares the enable, so a frozen cycle stalls the whole chain
    // coherently and never counts toward latency.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic [c_VEC_W-1:0] w_stage_d;

            if (k == 0) begin : g_head
                assign w_stage_d = din;
            end else begin : g_link
                assign w_stage_d = w_stage_q[k-1];
            end

            lane_delay_stage #(
                .DATA_W (c_VEC_W)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .i_en  (en),
                .i_d   (w_stage_d),
                .o_q   (w_stage_q[k])
            );
        end
    endgenerate

    assign dout = w_stage_q[DEPTH-1];

endmodule : lane_delay_fifo
`default_nettype wire

// File: tb/tb_lane_delay_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_delay_fifo
// Purpose  : Scoreboard bench for both deployed delay-line configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_delay_fifo;
    import lane_delay_fifo_pkg::*;

    localparam int LN = SA_LANES;
    localparam int DA = PSUM_FIFO_DEPTH;
    localparam int WA = PSUM_WIDTH;
    localparam int DB = OPND_FIFO_DEPTH;
    localparam int WB = OPND_WIDTH;
    localparam int VA = LN * WA;
    localparam int VB = LN * WB;

    logic clk;
    logic rst_a, en_a, rst_b, en_b;
    logic [VA-1:0] din_a, dout_a;
    logic [VB-1:0] din_b, dout_b;

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 0;

    initial clk = 1'b0;
    always #(CLK_HALF_PERIOD_NS) clk = ~clk;

    lane_delay_fifo #(.DEPTH(DA), .LANES(LN), .WIDTH(WA)) u_psum (
        .clk(clk), .reset(rst_a), .en(en_a), .din(din_a), .dout(dout_a)
    );

    lane_delay_fifo #(.DEPTH(DB), .LANES(LN), .WIDTH(WB)) u_opnd (
        .clk(clk), .reset(rst_b), .en(en_b), .din(din_b), .dout(dout_b)
    );

    task automatic check(input string name, input logic [VA-1:0] act, input logic [VA-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Push j carries -(i+1)(j+1) in lane i, truncated to the lane width.
    function automatic logic [VA-1:0] pat_a(input int j);
        logic [VA-1:0] v = '0;
        for (int i = 0; i < LN; i++) v[(LN-i)*WA-1 -: WA] = WA'(-((i+1)*(j+1)));
        return v;
    endfunction

    function automatic logic [VB-1:0] pat_b(input int j);
        logic [VB-1:0] v = '0;
        for (int i = 0; i < LN; i++) v[(LN-i)*WB-1 -: WB] = WB'(-((i+1)*(j+1)));
        return v;
    endfunction

    function automatic logic [VA-1:0] rnd_a();
        logic [VA-1:0] v = '0;
        for (int w = 0; w < VA/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [WA-1:0] lane_a(input logic [VA-1:0] v, input int i);
        return v[(LN-i)*WA-1 -: WA];
    endfunction

    function automatic logic [WB-1:0] lane_b(input logic [VB-1:0] v, input int i);
        return v[(LN-i)*WB-1 -: WB];
    endfunction

    // ---------------- scoreboards ----------------
    logic [VA-1:0] q_a[$];
    logic [VB-1:0] q_b[$];
    logic [VA-1:0] last_a;
    logic [VB-1:0] last_b;
    bit fired_a, fired_b;

    always @(posedge clk) begin
        fired_a = en_a && !rst_a;
        fired_b = en_b && !rst_b;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_a) begin
                check("psum_in_reset", dout_a, '0);
            end else if (fired_a) begin
                if (q_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL psum_sb_underflow t=%0t: got empty queue required entry", $time);
                end else begin
                    last_a = q_a.pop_front();
                    check("psum_stream", dout_a, last_a);
                end
            end else begin
                check("psum_hold", dout_a, last_a);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_b) begin
                check("opnd_in_reset", VA'(dout_b), '0);
            end else if (fired_b) begin
                if (q_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL opnd_sb_underflow t=%0t: got empty queue required entry", $time);
                end else begin
                    last_b = q_b.pop_front();
                    check("opnd_stream", VA'(dout_b), VA'(last_b));
                end
            end else begin
                check("opnd_hold", VA'(dout_b), VA'(last_b));
            end
        end
    end

    // ---------------- stimulus tasks (entered at posedge+1) ----------------
    task automatic reset_a(input logic en_v, input logic [VA-1:0] d);
        rst_a = 1'b1; en_a = en_v; din_a = d;
        q_a.delete();
        repeat (DA-1) q_a.push_back('0);
        last_a = '0;
        #1;
        if (mon_on) check("psum_reset_async", dout_a, '0);
        @(posedge clk); #1;
        rst_a = 1'b0; en_a = 1'b0;
    endtask

    task automatic reset_b(input logic en_v, input logic [VB-1:0] d);
        rst_b = 1'b1; en_b = en_v; din_b = d;
        q_b.delete();
        repeat (DB-1) q_b.push_back('0);
        last_b = '0;
        #1;
        if (mon_on) check("opnd_reset_async", VA'(dout_b), '0);
        @(posedge clk); #1;
        rst_b = 1'b0; en_b = 1'b0;
    endtask

    task automatic push_a(input logic [VA-1:0] v);
        en_a = 1'b1; din_a = v;
        q_a.push_back(v);
        @(posedge clk); #1;
        en_a = 1'b0;
    endtask

    task automatic push_b(input logic [VB-1:0] v);
        en_b = 1'b1; din_b = v;
        q_b.push_back(v);
        @(posedge clk); #1;
        en_b = 1'b0;
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin
            en_a = 1'b0; din_a = rnd_a();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #(200000 * CLK_PERIOD_NS);
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VA-1:0] v;
        rst_a = 1'b0; en_a = 1'b0; din_a = '0;
        rst_b = 1'b0; en_b = 1'b0; din_b = '0;
        @(posedge clk); #1;
        reset_a(1'b0, '0);
        reset_b(1'b0, '0);
        mon_on = 1'b1;

        // Reset pulse with en high and busy din; data pushed afterwards.
        reset_a(1'b1, {LN{20'h5A5A5}});
        for (int j = 0; j < 20; j++) begin
            push_a({LN{20'h12345}} ^ VA'(j + 1));
            if (j == DA-2) check("psum_zero_after_reset", dout_a, '0);
        end

        // Streaming with freeze and resume.
        reset_a(1'b0, '0);
        for (int j = 0; j < 30; j++) begin
            push_a(pat_a(j));
            if (j == DA-1) begin
                check("psum_first_lane0", VA'(lane_a(dout_a, 0)), VA'(20'hFFFFF));
                check("psum_first_lane15", VA'(lane_a(dout_a, 15)), VA'(20'hFFFF0));
            end
        end
        check("psum_push14_lane0", VA'(lane_a(dout_a, 0)), VA'(20'hFFFF1));
        idle_a(30);
        check("psum_frozen_lane0", VA'(lane_a(dout_a, 0)), VA'(20'hFFFF1));
        check("psum_frozen_lane15", VA'(lane_a(dout_a, 15)), VA'(20'hFFF10));
        push_a(pat_a(30));
        check("psum_resume_lane0", VA'(lane_a(dout_a, 0)), VA'(20'hFFFF0));
        for (int j = 31; j < 50; j++) begin
            push_a(pat_a(j));
            idle_a(j % 3);
        end

        // Lane packing: only lane 0 carries data.
        reset_a(1'b0, '0);
        v = '0;
        v[VA-1 -: WA] = 20'hABCDE;
        push_a(v);
        for (int j = 0; j < DA-1; j++) push_a('0);
        v = '0;
        v[VA-1 -: WA] = 20'hABCDE;
        check("psum_lane_packing", dout_a, v);

        // Operand path: long latency, then a mid-stream reset.
        reset_b(1'b0, '0);
        for (int j = 0; j < 300; j++) begin
            push_b(pat_b(j));
            if (j == DB-2) check("opnd_zero_before_first", VA'(dout_b), '0);
            if (j == DB-1) begin
                check("opnd_first_lane0", VA'(lane_b(dout_b, 0)), VA'(8'hFF));
                check("opnd_first_lane15", VA'(lane_b(dout_b, 15)), VA'(8'hF0));
            end
            if (j == DB+28) check("opnd_push29_lane15", VA'(lane_b(dout_b, 15)), VA'(8'h20));
        end
        reset_b(1'b1, {LN{8'hC3}});
        for (int j = 0; j < 260; j++) begin
            push_b(pat_b(j + 1000));
            if (j == DB-2) check("opnd_no_stale_data", VA'(dout_b), '0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lane_delay_fifo
`default_nettype wire
